alu_seq: RTL
============

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port s  input  8  source operand, taken from the register group source read port.
REQ-004 SHALL have port d  input  8  destination operand, taken from the register group destination read port.
REQ-005 SHALL have port op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT, 101 SHL, 110 SHR, 111 MUL.
REQ-006 SHALL have port start  input  1  request pulse; sampled only in IDLE.
REQ-007 SHALL have port result  output  8  registered result; drives the register group write-data input i.
REQ-008 SHALL have port we  output  1  active-low write enable to the register group.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port cf  output  1  carry/borrow/overflow flag, registered.
REQ-012 SHALL have port zf  output  1  zero flag, registered.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, MUL, WB.
REQ-014 SHALL, in IDLE with start=1 at a rising edge, latch s, d and op into internal operand registers.
- That edge moves the FSM to MUL when op=111, otherwise to EXEC.
REQ-015 SHALL ignore start while busy=1; no request is queued.
REQ-016 SHALL, in EXEC, register result and flags at the next edge, then move to WB.
REQ-017 SHALL compute the EXEC opcodes on the latched operands as:
- ADD: result=s+d, cf=carry out.
- SUB: result=s-d mod 256, cf=1 iff s<d.
- AND/OR: result=s&d or s|d, cf=0.
- NOT: result=~s, cf=0.
- SHL: result={s[6:0],0}, cf=s[7].
- SHR: result={0,s[7:1]}, cf=s[0].
REQ-018 SHALL, in MUL, perform an 8-step shift-add multiply of s by d using a 16-bit accumulator and a 3-bit step counter.
- One step per clock.
- After the 8th step: result=acc[7:0], cf=|acc[15:8], state moves to WB.
REQ-019 SHALL set zf=1 iff the new result equals 0x00, for every opcode.
REQ-020 SHALL, in WB, drive we=0 and done=1 for exactly one cycle, then return to IDLE.
- The register group captures result on the falling edge inside WB.
REQ-021 SHALL hold we=1 and done=0 in all states other than WB.
REQ-022 SHALL keep result, cf and zf stable from WB until the next operation's EXEC/MUL completion.
REQ-023 SHALL meet these latencies, counted from the start-sampling edge k:
- Non-MUL: WB occupies the cycle after edge k+2.
- MUL: WB occupies the cycle after edge k+9.
REQ-024 SHALL accept a new start in IDLE on the edge immediately following WB.
REQ-025 SHALL be unaffected by changes on s, d or op after the latching edge.

Reset
REQ-026 SHALL, while rst=1, immediately force:
- state=IDLE
- result=0x00, cf=0, zf=0
- we=1, busy=0, done=0
- internal operand, accumulator and counter registers to 0.
REQ-027 SHALL abort any operation in progress on reset with no write strobe issued; flags keep their reset values.
REQ-028 SHALL leave IDLE only on a start sampled after rst is deasserted.

Verification
REQ-029 ADD s=0xF0, d=0x20, start pulse -> result=0x10, cf=1, zf=0; one we=0/done=1 cycle at k+2; busy high k..k+2.
REQ-030 SUB s=0x05, d=0x05 -> result=0x00, zf=1, cf=0; SUB s=0x03, d=0x05 -> result=0xFE, cf=1.
REQ-031 MUL s=0x10, d=0x11 -> result=0x10, cf=1, WB at k+9.
- MUL s=0x0C, d=0x0A -> result=0x78, cf=0.
- start pulses during MUL are ignored.
REQ-032 SHL s=0x81 -> result=0x02, cf=1; SHR s=0x01 -> result=0x00, cf=1, zf=1.
REQ-033 Assert rst mid-MUL (step 4) -> all outputs at reset values within the same cycle; no we=0 pulse; next op after rst release executes correctly.
REQ-034 Back-to-back ops with start held high continuously -> each op produces exactly one WB pulse, spaced by one IDLE cycle.

Source files
------------

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Sequential 8-bit ALU with an 8-step shift-add multiplier and one write strobe per op.
// Revision : 1.0
// ============================================================================
module alu_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s,
  input  logic [7:0] d,
  input  logic [2:0] op,
  input  logic       start,
  output logic [7:0] result,
  output logic       we,
  output logic       busy,
  output logic       done,
  output logic       cf,
  output logic       zf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    WB   = 2'd3
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  state_t      state;
  state_t      state_next;
  logic        load;
  logic [7:0]  op_s;
  logic [7:0]  op_d;
  logic [2:0]  op_code;
  logic [15:0] acc;
  logic [2:0]  step;
  logic [8:0]  alu_full;
  logic [15:0] addend;
  logic [15:0] acc_sum;
  logic        mul_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign mul_last = (step == 3'd7);

  always_comb begin
    state_next = state;
    load       = 1'b0;
    busy       = 1'b1;
    we         = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          load       = 1'b1;
          state_next = (op == OP_MUL) ? MUL : EXEC;
        end
      end
      EXEC: state_next = WB;
      MUL: begin
        if (mul_last) begin
          state_next = WB;
        end
      end
      WB: begin
        we         = 1'b0;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bit 8 carries the carry, borrow or shifted-out bit for the EXEC opcodes.
  always_comb begin
    alu_full = 9'd0;
    case (op_code)
      OP_ADD:  alu_full = {1'b0, op_s} + {1'b0, op_d};
      OP_SUB:  alu_full = {1'b0, op_s} - {1'b0, op_d};
      OP_AND:  alu_full = {1'b0, op_s & op_d};
      OP_OR:   alu_full = {1'b0, op_s | op_d};
      OP_NOT:  alu_full = {1'b0, ~op_s};
      OP_SHL:  alu_full = {op_s[7], op_s[6:0], 1'b0};
      OP_SHR:  alu_full = {op_s[0], 1'b0, op_s[7:1]};
      default: alu_full = 9'd0;
    endcase
  end

  // The full 16-bit product never exceeds the accumulator, so no carry is lost.
  assign addend  = op_d[step] ? ({8'd0, op_s} << step) : 16'd0;
  assign acc_sum = acc + addend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_s    <= 8'd0;
      op_d    <= 8'd0;
      op_code <= 3'd0;
      acc     <= 16'd0;
      step    <= 3'd0;
      result  <= 8'd0;
      cf      <= 1'b0;
      zf      <= 1'b0;
    end else begin
      if (load) begin
        op_s    <= s;
        op_d    <= d;
        op_code <= op;
        acc     <= 16'd0;
        step    <= 3'd0;
      end
      if (state == EXEC) begin
        result <= alu_full[7:0];
        cf     <= alu_full[8];
        zf     <= (alu_full[7:0] == 8'd0);
      end
      if (state == MUL) begin
        acc  <= acc_sum;
        step <= step + 3'd1;
        if (mul_last) begin
          result <= acc_sum[7:0];
          cf     <= |acc_sum[15:8];
          zf     <= (acc_sum[7:0] == 8'd0);
        end
      end
    end
  end

endmodule
`default_nettype wire
